// File: rtl/paddle_mover.sv
// ============================================================================
// paddle_mover
// ----------------------------------------------------------------------------
// Object-motion controller for the SVGA game pipeline. Owns the on-screen
// object's position, moves it once every FRAMES_PER_ACTION frames from the
// direction buttons (with speed ramping), the accelerometer, or an autonomous
// bounce pattern, and produces the registered per-pixel draw strobe consumed
// by the RGB mux.
//
// Build option:
//   PADDLE_AUTO_EN  defined   -> AUTO bounce mode compiled in, mode cycles
//                                BUTTONS -> ACCEL -> AUTO -> BUTTONS
//                   undefined -> no AUTO logic, mode cycles BUTTONS <-> ACCEL
//
// Ports:
//   pixel_clk           in   1   pixel clock, all logic on rising edge
//   rst                 in   1   synchronous active-high reset
//   h_coord             in  11   current pixel column
//   v_coord             in  10   current pixel row
//   button_u/d/l/r      in   1   debounced direction levels
//   button_c            in   1   mode-change level, rising edge acts
//   accel_x, accel_y    in   8   signed two's-complement tilt
//   obj_h               out 11   object left edge
//   obj_v               out 10   object top edge
//   obj_draw            out  1   current pixel lies inside the object (1-cycle latency)
//   mode                out  2   0 BUTTONS, 1 ACCEL, 2 AUTO
//   speed_h             out  5   current horizontal button speed
// ============================================================================
module paddle_mover #(
    parameter int SCREEN_W          = 800,
    parameter int SCREEN_H          = 600,
    parameter int OBJ_W             = 150,
    parameter int OBJ_H             = 10,
    parameter int FRAMES_PER_ACTION = 3,
    parameter int SPEED_MIN         = 5,
    parameter int SPEED_MAX         = 20,
    parameter int SPEED_STEP        = 1,
    parameter int ACCEL_DEADBAND    = 2
) (
    input  logic              pixel_clk,
    input  logic              rst,
    input  logic [10:0]       h_coord,
    input  logic [9:0]        v_coord,
    input  logic              button_u,
    input  logic              button_d,
    input  logic              button_l,
    input  logic              button_r,
    input  logic              button_c,
    input  logic signed [7:0] accel_x,
    input  logic signed [7:0] accel_y,
    output logic [10:0]       obj_h,
    output logic [9:0]        obj_v,
    output logic              obj_draw,
    output logic [1:0]        mode,
    output logic [4:0]        speed_h
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int FC_W = (FRAMES_PER_ACTION > 1) ? $clog2(FRAMES_PER_ACTION) : 1;

    localparam logic [FC_W-1:0] FC_LAST   = FC_W'(FRAMES_PER_ACTION - 1);
    localparam logic [10:0]     LAST_H    = 11'(SCREEN_W - 1);
    localparam logic [9:0]      LAST_V    = 10'(SCREEN_H - 1);
    localparam logic [11:0]     MAX_H     = 12'(SCREEN_W - OBJ_W);
    localparam logic [11:0]     MAX_V     = 12'(SCREEN_H - OBJ_H);
    localparam logic [10:0]     RST_H     = 11'((SCREEN_W - OBJ_W) / 2);
    localparam logic [9:0]      RST_V     = 10'(SCREEN_H - OBJ_H - 90);
    localparam logic [4:0]      SPD_MIN   = 5'(SPEED_MIN);
    localparam logic [11:0]     STEP_MIN  = 12'(SPEED_MIN);
    localparam logic signed [7:0] DB_POS  = 8'(ACCEL_DEADBAND);
    localparam logic signed [7:0] DB_NEG  = 8'(-ACCEL_DEADBAND);

    typedef enum logic [1:0] {
        MODE_BUTTONS = 2'd0,
        MODE_ACCEL   = 2'd1,
        MODE_AUTO    = 2'd2
    } mode_e;

    // Direction of the previous button move on one axis; used to decide
    // whether a held button keeps ramping or restarts at the minimum speed.
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_NEG  = 2'd1,
        DIR_POS  = 2'd2
    } dir_e;

    // Outcome of the button rules for one axis on an action tick.
    typedef struct packed {
        logic       move;
        logic       inc;
        logic [4:0] step;
        logic [4:0] speed;
        dir_e       last;
    } btn_axis_t;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    // Saturating speed ramp: min(s + SPEED_STEP, SPEED_MAX).
    function automatic logic [4:0] ramp(input logic [4:0] s);
        logic [5:0] t;
        t = {1'b0, s} + 6'(SPEED_STEP);
        if (t > 6'(SPEED_MAX)) ramp = 5'(SPEED_MAX);
        else                   ramp = 5'(t);
    endfunction

    // Move pos by step toward +/- and clamp into [0, lim]. The sum is formed
    // one bit wider than the coordinate so an overshoot can never wrap.
    function automatic logic [11:0] clamp_move(input logic [11:0] pos,
                                               input logic [11:0] step,
                                               input logic        inc,
                                               input logic [11:0] lim);
        logic [12:0] sum;
        if (inc) begin
            sum = {1'b0, pos} + {1'b0, step};
            if (sum > {1'b0, lim}) clamp_move = lim;
            else                   clamp_move = 12'(sum);
        end else begin
            sum = '0;
            if (pos < step) clamp_move = '0;
            else            clamp_move = pos - step;
        end
    endfunction

    // True when the same move would be limited by the clamp.
    function automatic logic clamp_hit(input logic [11:0] pos,
                                       input logic [11:0] step,
                                       input logic        inc,
                                       input logic [11:0] lim);
        if (inc) clamp_hit = ({1'b0, pos} + {1'b0, step}) > {1'b0, lim};
        else     clamp_hit = pos < step;
    endfunction

    // Button rules for one axis. A move in the same direction as the previous
    // action uses the ramped speed; a new direction restarts at SPEED_MIN.
    // Either way the stored speed is the step just used, ramped once.
    function automatic btn_axis_t button_axis(input logic       neg,
                                              input logic       pos,
                                              input logic [4:0] speed,
                                              input dir_e       last);
        btn_axis_t res;
        dir_e      d;
        res.move  = 1'b0;
        res.inc   = 1'b0;
        res.step  = SPD_MIN;
        res.speed = SPD_MIN;
        res.last  = DIR_NONE;
        if (neg ^ pos) begin
            d         = pos ? DIR_POS : DIR_NEG;
            res.move  = 1'b1;
            res.inc   = pos;
            res.step  = (d == last) ? speed : SPD_MIN;
            res.speed = ramp(res.step);
            res.last  = d;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    mode_e           r_mode;
    mode_e           w_mode_next;
    logic            r_eof;
    logic [FC_W-1:0] r_frame_cnt;
    logic            r_btn_c_d;
    logic            r_obj_draw;
    logic [10:0]     r_obj_h,   w_obj_h_next;
    logic [9:0]      r_obj_v,   w_obj_v_next;
    logic [4:0]      r_speed_h, w_speed_h_next;
    logic [4:0]      r_speed_v, w_speed_v_next;
    dir_e            r_last_h,  w_last_h_next;
    dir_e            r_last_v,  w_last_v_next;
`ifdef PADDLE_AUTO_EN
    logic            r_dir_h,   w_dir_h_next;   // 1 = moving toward +
    logic            r_dir_v,   w_dir_v_next;
`endif

    logic            w_action;
    logic            w_c_rise;
    logic            w_in_h;
    logic            w_in_v;
    btn_axis_t       w_btn_h;
    btn_axis_t       w_btn_v;

    assign w_action = r_eof && (r_frame_cnt == '0);
    assign w_c_rise = button_c && !r_btn_c_d;

    assign w_in_h = ({1'b0, h_coord} >= {1'b0, r_obj_h}) &&
                    ({1'b0, h_coord} <= ({1'b0, r_obj_h} + 12'(OBJ_W - 1)));
    assign w_in_v = ({1'b0, v_coord} >= {1'b0, r_obj_v}) &&
                    ({1'b0, v_coord} <= ({1'b0, r_obj_v} + 11'(OBJ_H - 1)));

    // ------------------------------------------------------------------------
    // Mode state register
    // ------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge pixel_clk) begin
        if (rst) r_mode <= MODE_BUTTONS;
        else     r_mode <= w_mode_next;
    end

    // ------------------------------------------------------------------------
    // Next-state: mode sequencing and per-axis motion
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        w_mode_next    = r_mode;
        w_obj_h_next   = r_obj_h;
        w_obj_v_next   = r_obj_v;
        w_speed_h_next = r_speed_h;
        w_speed_v_next = r_speed_v;
        w_last_h_next  = r_last_h;
        w_last_v_next  = r_last_v;
`ifdef PADDLE_AUTO_EN
        w_dir_h_next   = r_dir_h;
        w_dir_v_next   = r_dir_v;
`endif
        w_btn_h = button_axis(button_l, button_r, r_speed_h, r_last_h);
        w_btn_v = button_axis(button_u, button_d, r_speed_v, r_last_v);

        if (w_c_rise) begin
            // A mode change wins over a coincident action: no move this tick.
            case (r_mode)
                MODE_BUTTONS: w_mode_next = MODE_ACCEL;
`ifdef PADDLE_AUTO_EN
                MODE_ACCEL:   w_mode_next = MODE_AUTO;
`else
                MODE_ACCEL:   w_mode_next = MODE_BUTTONS;
`endif
                default:      w_mode_next = MODE_BUTTONS;
            endcase
            w_speed_h_next = SPD_MIN;
            w_speed_v_next = SPD_MIN;
            w_last_h_next  = DIR_NONE;
            w_last_v_next  = DIR_NONE;
`ifdef PADDLE_AUTO_EN
            w_dir_h_next   = 1'b1;
            w_dir_v_next   = 1'b1;
`endif
        end else if (w_action) begin
            case (r_mode)
                MODE_BUTTONS: begin
                    if (w_btn_h.move)
                        w_obj_h_next = 11'(clamp_move({1'b0, r_obj_h}, 12'(w_btn_h.step),
                                                      w_btn_h.inc, MAX_H));
                    if (w_btn_v.move)
                        w_obj_v_next = 10'(clamp_move({2'b0, r_obj_v}, 12'(w_btn_v.step),
                                                      w_btn_v.inc, MAX_V));
                    w_speed_h_next = w_btn_h.speed;
                    w_speed_v_next = w_btn_v.speed;
                    w_last_h_next  = w_btn_h.last;
                    w_last_v_next  = w_btn_v.last;
                end
                MODE_ACCEL: begin
                    // Positive y tilt moves left, negative right; negative x
                    // tilt moves up, positive down. Inside the deadband: still.
                    if ((accel_y > DB_POS) || (accel_y < DB_NEG))
                        w_obj_h_next = 11'(clamp_move({1'b0, r_obj_h}, STEP_MIN,
                                                      accel_y < DB_NEG, MAX_H));
                    if ((accel_x > DB_POS) || (accel_x < DB_NEG))
                        w_obj_v_next = 10'(clamp_move({2'b0, r_obj_v}, STEP_MIN,
                                                      accel_x > DB_POS, MAX_V));
                end
`ifdef PADDLE_AUTO_EN
                MODE_AUTO: begin
                    // Bounce: a clamped move parks on the limit and reverses.
                    w_obj_h_next = 11'(clamp_move({1'b0, r_obj_h}, STEP_MIN, r_dir_h, MAX_H));
                    w_obj_v_next = 10'(clamp_move({2'b0, r_obj_v}, STEP_MIN, r_dir_v, MAX_V));
                    if (clamp_hit({1'b0, r_obj_h}, STEP_MIN, r_dir_h, MAX_H))
                        w_dir_h_next = ~r_dir_h;
                    if (clamp_hit({2'b0, r_obj_v}, STEP_MIN, r_dir_v, MAX_V))
                        w_dir_v_next = ~r_dir_v;
                end
`endif
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Frame tick, edge detect, draw strobe and position/speed registers
    // ------------------------------------------------------------------------
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_eof       <= 1'b0;
            r_frame_cnt <= '0;
            r_btn_c_d   <= 1'b0;
            r_obj_draw  <= 1'b0;
            r_obj_h     <= RST_H;
            r_obj_v     <= RST_V;
            r_speed_h   <= SPD_MIN;
            r_speed_v   <= SPD_MIN;
            r_last_h    <= DIR_NONE;
            r_last_v    <= DIR_NONE;
`ifdef PADDLE_AUTO_EN
            r_dir_h     <= 1'b1;
            r_dir_v     <= 1'b1;
`endif
        end else begin
            r_eof      <= (h_coord == LAST_H) && (v_coord == LAST_V);
            r_btn_c_d  <= button_c;
            r_obj_draw <= w_in_h && w_in_v;
            // frame_cnt advances after action is sampled, so the first eof
            // after reset (count 0) is an action tick.
            if (r_eof)
                r_frame_cnt <= (r_frame_cnt == FC_LAST) ? '0 : r_frame_cnt + FC_W'(1);
            r_obj_h   <= w_obj_h_next;
            r_obj_v   <= w_obj_v_next;
            r_speed_h <= w_speed_h_next;
            r_speed_v <= w_speed_v_next;
            r_last_h  <= w_last_h_next;
            r_last_v  <= w_last_v_next;
`ifdef PADDLE_AUTO_EN
            r_dir_h   <= w_dir_h_next;
            r_dir_v   <= w_dir_v_next;
`endif
        end
    end

    assign obj_h    = r_obj_h;
    assign obj_v    = r_obj_v;
    assign obj_draw = r_obj_draw;
    assign mode     = r_mode;
    assign speed_h  = r_speed_h;

endmodule

// File: tb/tb_paddle_mover.sv
// ============================================================================
// tb_paddle_mover
// ----------------------------------------------------------------------------
// Self-checking bench for paddle_mover. Coordinates are driven sparsely: a
// "frame" is a few probe pixels around the object, one last-pixel cycle and
// two trailing probes, so every frame produces exactly one eof. A behavioural
// model (signed integer positions, clamps as min/max, direction as -1/0/+1)
// predicts every output on every cycle.
// ============================================================================
module tb_paddle_mover;

    localparam int SCREEN_W   = 800;
    localparam int SCREEN_H   = 600;
    localparam int OBJ_W      = 150;
    localparam int OBJ_H      = 10;
    localparam int FPA        = 3;
    localparam int SPEED_MIN  = 5;
    localparam int SPEED_MAX  = 20;
    localparam int SPEED_STEP = 1;
    localparam int DB         = 2;
    localparam int MAX_H      = SCREEN_W - OBJ_W;
    localparam int MAX_V      = SCREEN_H - OBJ_H;
`ifdef PADDLE_AUTO_EN
    localparam int N_MODES    = 3;
`else
    localparam int N_MODES    = 2;
`endif

    logic              pixel_clk = 1'b0;
    logic              rst;
    logic [10:0]       h_coord;
    logic [9:0]        v_coord;
    logic              button_u, button_d, button_l, button_r, button_c;
    logic signed [7:0] accel_x, accel_y;
    logic [10:0]       obj_h;
    logic [9:0]        obj_v;
    logic              obj_draw;
    logic [1:0]        mode;
    logic [4:0]        speed_h;

    always #5 pixel_clk = ~pixel_clk;

    paddle_mover #(
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .OBJ_W(OBJ_W), .OBJ_H(OBJ_H),
        .FRAMES_PER_ACTION(FPA), .SPEED_MIN(SPEED_MIN), .SPEED_MAX(SPEED_MAX),
        .SPEED_STEP(SPEED_STEP), .ACCEL_DEADBAND(DB)
    ) dut (
        .pixel_clk(pixel_clk), .rst(rst),
        .h_coord(h_coord), .v_coord(v_coord),
        .button_u(button_u), .button_d(button_d),
        .button_l(button_l), .button_r(button_r), .button_c(button_c),
        .accel_x(accel_x), .accel_y(accel_y),
        .obj_h(obj_h), .obj_v(obj_v), .obj_draw(obj_draw),
        .mode(mode), .speed_h(speed_h)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_h, m_v, m_mode, m_sh, m_sv, m_lh, m_lv, m_dh, m_dv;
    int m_eof, m_fcnt, m_cprev, m_draw, m_actions = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int x, input int lim);
        if (x < 0)   return 0;
        if (x > lim) return lim;
        return x;
    endfunction

    // Button rules on one axis; dir is -1, 0 or +1 (0 covers neither/both).
    task automatic btn_axis(input int dir, input int lim, inout int pos, inout int spd, inout int last);
        int stp;
        if (dir != 0) begin
            stp  = (dir == last) ? spd : SPEED_MIN;
            pos  = clampi(pos + dir * stp, lim);
            spd  = (stp + SPEED_STEP > SPEED_MAX) ? SPEED_MAX : stp + SPEED_STEP;
            last = dir;
        end else begin
            spd  = SPEED_MIN;
            last = 0;
        end
    endtask

    task automatic auto_axis(input int lim, inout int pos, inout int dir);
        int np;
        np = pos + dir * SPEED_MIN;
        if (np > lim)    begin pos = lim; dir = -dir; end
        else if (np < 0) begin pos = 0;   dir = -dir; end
        else             pos = np;
    endtask

    task automatic model_reset();
        m_h = (SCREEN_W - OBJ_W) / 2;  m_v = SCREEN_H - OBJ_H - 90;
        m_mode = 0; m_sh = SPEED_MIN; m_sv = SPEED_MIN; m_lh = 0; m_lv = 0;
        m_dh = 1; m_dv = 1; m_eof = 0; m_fcnt = 0; m_cprev = 0; m_draw = 0;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        int act, rise, nd, ne, ax, ay, dh, dv;
        act  = (m_eof != 0) && (m_fcnt == 0);
        rise = (button_c == 1'b1) && (m_cprev == 0);
        nd   = (int'(h_coord) >= m_h) && (int'(h_coord) < m_h + OBJ_W) &&
               (int'(v_coord) >= m_v) && (int'(v_coord) < m_v + OBJ_H);
        ne   = (int'(h_coord) == SCREEN_W - 1) && (int'(v_coord) == SCREEN_H - 1);
        if (rst) begin
            model_reset();
            return;
        end
        if (m_eof != 0) m_fcnt = (m_fcnt + 1) % FPA;
        m_eof = ne; m_draw = nd; m_cprev = button_c;
        if (act) m_actions++;
        if (rise) begin
            m_mode = (m_mode + 1) % N_MODES;
            m_sh = SPEED_MIN; m_sv = SPEED_MIN; m_lh = 0; m_lv = 0; m_dh = 1; m_dv = 1;
        end else if (act) begin
            case (m_mode)
                0: begin
                    btn_axis(int'(button_r) - int'(button_l), MAX_H, m_h, m_sh, m_lh);
                    btn_axis(int'(button_d) - int'(button_u), MAX_V, m_v, m_sv, m_lv);
                end
                1: begin
                    ax = int'(accel_x); ay = int'(accel_y);
                    dh = (ay > DB) ? -1 : ((ay < -DB) ? 1 : 0);
                    dv = (ax < -DB) ? -1 : ((ax > DB) ? 1 : 0);
                    m_h = clampi(m_h + dh * SPEED_MIN, MAX_H);
                    m_v = clampi(m_v + dv * SPEED_MIN, MAX_V);
                end
                default: begin
                    auto_axis(MAX_H, m_h, m_dh);
                    auto_axis(MAX_V, m_v, m_dv);
                end
            endcase
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge pixel_clk);
        #1;
        check("obj_h",    obj_h,    m_h);
        check("obj_v",    obj_v,    m_v);
        check("mode",     mode,     m_mode);
        check("speed_h",  speed_h,  m_sh);
        check("obj_draw", obj_draw, m_draw);
    endtask

    // Random pixel, biased to straddle the object's edges.
    task automatic set_probe();
        int h, v;
        h = m_h + int'($urandom_range(0, OBJ_W + 3)) - 2;
        v = m_v + int'($urandom_range(0, OBJ_H + 3)) - 2;
        if ($urandom_range(0, 3) == 0) begin
            h = int'($urandom_range(0, SCREEN_W - 1));
            v = int'($urandom_range(0, SCREEN_H - 1));
        end
        h = clampi(h, SCREEN_W - 1);
        v = clampi(v, SCREEN_H - 1);
        if (h == SCREEN_W - 1 && v == SCREEN_H - 1) v = 0;
        h_coord = 11'(h);
        v_coord = 10'(v);
    endtask

    // One frame: probes, last pixel, then the cycle in which eof is high.
    task automatic frame(input bit c_on_action);
        for (int i = 0; i < 4; i++) begin set_probe(); cyc(); end
        h_coord = 11'(SCREEN_W - 1); v_coord = 10'(SCREEN_H - 1); cyc();
        set_probe();
        if (c_on_action) button_c = 1'b1;
        cyc();
        button_c = 1'b0;
        set_probe(); cyc();
    endtask

    task automatic to_action();
        int start;
        start = m_actions;
        for (int f = 0; f < FPA + 1; f++) begin
            if (m_actions != start) break;
            frame(1'b0);
        end
    endtask

    task automatic pulse_c();
        button_c = 1'b1; set_probe(); cyc();
        button_c = 1'b0; set_probe(); cyc();
    endtask

    int exp_h[4] = '{320, 314, 307, 299};
    int draw_pts[6][3] = '{'{325, 500, 1}, '{474, 509, 1}, '{475, 509, 0},
                           '{324, 500, 0}, '{400, 510, 0}, '{400, 499, 0}};
    int saved_h, saved_v, exp_mode, a;

    initial begin
        rst = 1'b1; h_coord = '0; v_coord = '0;
        button_u = 0; button_d = 0; button_l = 0; button_r = 0; button_c = 0;
        accel_x = '0; accel_y = '0;
        model_reset();
        cyc(); cyc();
        check("rst_obj_h", obj_h, 325);
        check("rst_obj_v", obj_v, 500);
        check("rst_mode", mode, 0);
        check("rst_speed_h", speed_h, 5);
        check("rst_draw", obj_draw, 0);
        rst = 1'b0;

        // Idle frames, then the object's corner pixels.
        repeat (3) frame(1'b0);
        check("idle_obj_h", obj_h, 325);
        check("idle_obj_v", obj_v, 500);
        foreach (draw_pts[i]) begin
            h_coord = 11'(draw_pts[i][0]); v_coord = 10'(draw_pts[i][1]);
            cyc();
            check("draw_corner", obj_draw, draw_pts[i][2]);
        end

        // Held left ramps 5,6,7,8; release restores SPEED_MIN.
        button_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            to_action();
            check("ramp_left", obj_h, exp_h[i]);
        end
        button_l = 1'b0;
        to_action();
        check("release_speed", speed_h, 5);
        check("release_hold", obj_h, 299);

        // Reset in the middle of a held-left ramp.
        button_l = 1'b1;
        to_action(); to_action();
        set_probe(); cyc();
        rst = 1'b1; set_probe(); cyc();
        check("midrst_obj_h", obj_h, 325);
        check("midrst_speed", speed_h, 5);
        rst = 1'b0; button_l = 1'b0; button_r = 1'b1;
        frame(1'b0);
        check("first_eof_action", obj_h, 330);

        // Ramp right to 645, then clamp at 650.
        repeat (21) to_action();
        check("right_645", obj_h, 645);
        to_action();
        check("right_clamp", obj_h, 650);
        to_action();
        check("right_stay", obj_h, 650);
        button_l = 1'b1;
        to_action();
        check("both_nomove", obj_h, 650);
        check("both_speed", speed_h, 5);
        button_l = 1'b0; button_r = 1'b0;

        // ACCEL mode.
        accel_y = 8'sd3; accel_x = -8'sd2;
        pulse_c();
        check("accel_mode", mode, 1);
        check("accel_nomove", obj_h, 650);
        to_action();
        check("accel_left1", obj_h, 645);
        check("accel_v_still", obj_v, 500);
        to_action();
        check("accel_left2", obj_h, 640);
        accel_y = 8'sd2;
        to_action();
        check("accel_deadband", obj_h, 640);
        accel_y = -8'sd3;
        to_action();
        check("accel_right", obj_h, 645);
        accel_y = 8'sd0; accel_x = 8'sd3;
        to_action();
        check("accel_down", obj_v, 505);
        accel_x = -8'sd3;
        to_action();
        check("accel_up", obj_v, 500);
        accel_x = 8'sd0;

        // Second pulse: AUTO when compiled in, else back to BUTTONS.
        pulse_c();
`ifdef PADDLE_AUTO_EN
        check("mode_third", mode, 2);
        repeat (18) to_action();
        check("auto_v_top", obj_v, 590);
        check("auto_h_bounce", obj_h, 570);
        repeat (2) to_action();
        check("auto_v_down", obj_v, 585);
`else
        check("mode_wrap", mode, 0);
        to_action();
        check("buttons_idle", obj_h, 645);
`endif

        // Mode change coinciding with an action: no move that tick.
        for (int g = 0; g < FPA && m_fcnt != 0; g++) frame(1'b0);
        button_l = 1'b1; button_u = 1'b1;
        accel_y = 8'sd9; accel_x = -8'sd9;
        saved_h = m_h; saved_v = m_v;
        exp_mode = (m_mode + 1) % N_MODES;
        frame(1'b1);
        check("coincide_mode", mode, exp_mode);
        check("coincide_h", obj_h, saved_h);
        check("coincide_v", obj_v, saved_v);
        button_l = 1'b0; button_u = 1'b0;

        // Randomised phase.
        for (int n = 0; n < 220; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                button_l = ($urandom_range(0, 2) == 0);
                button_r = ($urandom_range(0, 2) == 0);
                button_u = ($urandom_range(0, 2) == 0);
                button_d = ($urandom_range(0, 2) == 0);
            end
            a = int'($urandom_range(0, 12)) - 6;
            accel_x = 8'(a);
            a = int'($urandom_range(0, 12)) - 6;
            accel_y = 8'(a);
            if ($urandom_range(0, 7) == 0) accel_y = 8'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1; set_probe(); cyc(); rst = 1'b0;
            end
            if ($urandom_range(0, 11) == 0) pulse_c();
            frame($urandom_range(0, 15) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
